// File: rtl/sumador_secuencial_if.sv
// rtl/sumador_secuencial_if.sv - request/result bundle of the multi-word add/subtract sequencer
interface sumador_secuencial_if #(
  parameter int N = 8,
  parameter int W = 4
);
  logic           start;
  logic           resta;
  logic [N*W-1:0] A;
  logic [N*W-1:0] B;
  logic           Cin;
  logic [N*W-1:0] S;
  logic           Cout;
  logic           V;
  logic           busy;
  logic           done;

  modport master (
    output start, resta, A, B, Cin,
    input  S, Cout, V, busy, done
  );

  modport slave (
    input  start, resta, A, B, Cin,
    output S, Cout, V, busy, done
  );
endinterface

// File: rtl/sumador_secuencial.sv
// rtl/sumador_secuencial.sv - N*W-bit add/subtract built from one N-bit adder over W cycles
module sumador #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         v
);
  always_comb begin
    {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    v         = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
  end
endmodule

module sumador_secuencial #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sumador_secuencial_if.slave   bus
);
  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(W - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SUMA = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             last;

  logic [N*W-1:0]   a_reg;
  logic [N*W-1:0]   b_reg;
  logic [N*W-1:0]   s_reg;
  logic             carry;
  logic             cout_reg;
  logic             v_reg;
  logic             done_reg;
  logic [IDX_W-1:0] idx;

  logic [N-1:0]     word_a;
  logic [N-1:0]     word_b;
  logic [N-1:0]     word_s;
  logic             word_cout;
  logic             word_v;

  assign word_a = a_reg[idx*N +: N];
  assign word_b = b_reg[idx*N +: N];

  sumador #(.N(N)) u_sumador (
    .a    (word_a),
    .b    (word_b),
    .cin  (carry),
    .s    (word_s),
    .cout (word_cout),
    .v    (word_v)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = SUMA;
        end
      end
      SUMA: begin
        if (idx == LAST) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is folded in at accept time: B is stored inverted and the carry seeded with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      s_reg    <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      v_reg    <= 1'b0;
      done_reg <= 1'b0;
      idx      <= '0;
    end else begin
      done_reg <= last;
      if (accept) begin
        a_reg <= bus.A;
        b_reg <= bus.resta ? ~bus.B : bus.B;
        carry <= bus.resta | bus.Cin;
        idx   <= '0;
      end else if (state == SUMA) begin
        s_reg[idx*N +: N] <= word_s;
        carry             <= word_cout;
        if (last) begin
          idx      <= '0;
          cout_reg <= word_cout;
          v_reg    <= word_v;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  assign bus.S    = s_reg;
  assign bus.Cout = cout_reg;
  assign bus.V    = v_reg;
  assign bus.busy = (state == SUMA);
  assign bus.done = done_reg;
endmodule
